// File: rtl/soc_system_nios2arm_sel_in.sv
// soc_system_nios2arm_sel_in
//   Avalon-MM slave that samples a selector bus coming from the Nios side,
//   captures edges on each bit and raises a level interrupt toward the ARM
//   side while any captured edge is unmasked.
//
//   Register map (word address):
//     0 DATA     RO  current sample of in_port
//     1 -        reserved, reads 0, writes ignored
//     2 IRQMASK  RW  per-bit interrupt enable
//     3 EDGECAP  R/W1C captured edges; a simultaneous new edge beats the clear
//
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     address, chipselect, write_n, writedata, readdata   Avalon-MM slave
//     in_port             selector input, asynchronous to clk
//     irq                 registered level interrupt, active-high
//
//   Parameters:
//     WIDTH      width of in_port and of the DATA/IRQMASK/EDGECAP registers (<= 32)
//     EDGE_TYPE  0 rising, 1 falling, 2 any edge
//
//   Build option:
//     NIOS2ARM_SEL_SYNC_EN  when defined, in_port passes through a 2-flop
//                           synchronizer before sampling (DATA/EDGECAP latency
//                           3 edges, irq 4); otherwise latency is 1 and 2.
module soc_system_nios2arm_sel_in #(
  parameter int WIDTH     = 4,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stage_in;
  logic [WIDTH-1:0] samp_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] set_vec;
  logic [WIDTH-1:0] clr_vec;
  logic             armed_q;
  logic             wr_en;
  logic             rd_en;
  logic [31:0]      rd_mux;

  // Only the low WIDTH bits of writedata are meaningful.
  wire unused_wdata = &{1'b0, writedata};

`ifdef NIOS2ARM_SEL_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  assign stage_in = sync2_q;
`else
  assign stage_in = in_port;
`endif

  // samp_q is the registered sample s (DATA). The edge is judged between the
  // value about to be registered and the one already held, so EDGECAP updates
  // on the same clock edge that DATA does.
  always_comb begin
    edge_vec = stage_in & ~samp_q;
    if (EDGE_TYPE == 1)
      edge_vec = ~stage_in & samp_q;
    else if (EDGE_TYPE == 2)
      edge_vec = stage_in ^ samp_q;
  end

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & write_n;

  // armed_q holds off capture on the first cycle after reset release, so a
  // level present at release is not mistaken for an edge.
  assign set_vec = armed_q ? edge_vec : '0;
  assign clr_vec = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = samp_q;
      2'd2:    rd_mux[WIDTH-1:0] = mask_q;
      2'd3:    rd_mux[WIDTH-1:0] = cap_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samp_q   <= '0;
      armed_q  <= 1'b0;
      cap_q    <= '0;
      mask_q   <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      samp_q  <= stage_in;
      armed_q <= 1'b1;
      // set is ORed in after the clear so a coincident edge survives
      cap_q   <= (cap_q & ~clr_vec) | set_vec;
      if (wr_en && address == 2'd2)
        mask_q <= writedata[WIDTH-1:0];
      irq <= |(cap_q & mask_q);
      if (rd_en)
        readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_soc_system_nios2arm_sel_in.sv
module tb_soc_system_nios2arm_sel_in;

`ifdef NIOS2ARM_SEL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rdata [3];
  logic        irq_v [3];

  int total;
  int bad;

  soc_system_nios2arm_sel_in #(.WIDTH(4), .EDGE_TYPE(0)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata[0]), .irq(irq_v[0]));

  soc_system_nios2arm_sel_in #(.WIDTH(4), .EDGE_TYPE(1)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata[1]), .irq(irq_v[1]));

  soc_system_nios2arm_sel_in #(.WIDTH(4), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata[2]), .irq(irq_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: history of in_port at every edge since reset release
  int          n_edges;
  logic [3:0]  hist [$];
  logic [3:0]  m_samp;
  logic [3:0]  m_mask;
  logic [3:0]  m_cap [3];
  logic [31:0] m_rd [3];
  logic        m_irq [3];

  typedef struct {
    bit          do_wr;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [3:0]  inp;
    logic [1:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [10];

  task automatic model_clear();
    n_edges = 0;
    hist.delete();
    m_samp = 4'h0;
    m_mask = 4'h0;
    for (int t = 0; t < 3; t++) begin
      m_cap[t] = 4'h0;
      m_rd[t]  = 32'h0;
      m_irq[t] = 1'b0;
    end
  endtask

  // Advance the model by one clock edge using the inputs now on the bus.
  task automatic model_edge();
    logic [3:0] cur;
    logic [3:0] e;
    logic [3:0] clr;
    int idx;
    hist.push_back(in_port);
    n_edges++;
    idx = n_edges - LAT + 1;
    cur = (idx >= 1) ? hist[idx-1] : 4'h0;
    clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
    for (int t = 0; t < 3; t++) begin
      if (t == 0)      e = cur & ~m_samp;
      else if (t == 1) e = ~cur & m_samp;
      else             e = cur ^ m_samp;
      if (chipselect && write_n) begin
        case (address)
          2'd0:    m_rd[t] = {28'h0, m_samp};
          2'd2:    m_rd[t] = {28'h0, m_mask};
          2'd3:    m_rd[t] = {28'h0, m_cap[t]};
          default: m_rd[t] = 32'h0;
        endcase
      end
      m_irq[t] = |(m_cap[t] & m_mask);
      m_cap[t] = (m_cap[t] & ~clr) | ((n_edges >= 2) ? e : 4'h0);
    end
    if (chipselect && !write_n && address == 2'd2)
      m_mask = writedata[3:0];
    m_samp = cur;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    for (int t = 0; t < 3; t++) begin
      chk($sformatf("model_rd[%0d]", t), rdata[t], m_rd[t]);
      chk($sformatf("model_irq[%0d]", t), {31'h0, irq_v[t]}, {31'h0, m_irq[t]});
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    step();
    chipselect = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    chipselect = 1'b0;
    write_n = 1'b1;
    address = 2'd0;
    writedata = 32'h0;
    in_port = 4'h0;
    model_clear();
    #3;
    for (int t = 0; t < 3; t++) begin
      chk("reset_rd", rdata[t], 32'h0);
      chk("reset_irq", {31'h0, irq_v[t]}, 32'h0);
    end
    #10 reset_n = 1'b1;

    // directed vectors, checked against the rising-edge instance
    vecs[0] = '{1'b1, 2'd2, 32'h0000_0004, 4'h0, 2'd2, 32'h4, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 32'h0,         4'h6, 2'd3, 32'h6, 1'b1};
    vecs[2] = '{1'b0, 2'd0, 32'h0,         4'h6, 2'd0, 32'h6, 1'b1};
    vecs[3] = '{1'b1, 2'd3, 32'h0000_0004, 4'h6, 2'd3, 32'h2, 1'b0};
    vecs[4] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 4'h6, 2'd0, 32'h6, 1'b0};
    vecs[5] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 4'h6, 2'd2, 32'h4, 1'b0};
    vecs[6] = '{1'b0, 2'd0, 32'h0,         4'hF, 2'd3, 32'hB, 1'b0};
    vecs[7] = '{1'b1, 2'd2, 32'h0000_000F, 4'h0, 2'd3, 32'hB, 1'b1};
    vecs[8] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 4'h0, 2'd3, 32'h0, 1'b0};
    vecs[9] = '{1'b1, 2'd2, 32'h0000_0004, 4'h0, 2'd2, 32'h4, 1'b0};

    for (int v = 0; v < 10; v++) begin
      in_port = vecs[v].inp;
      if (vecs[v].do_wr) wr(vecs[v].wa, vecs[v].wd);
      idle(LAT + 2);
      rd(vecs[v].ra);
      chk($sformatf("vec%0d_rd", v), rdata[0], vecs[v].exp_rd);
      chk($sformatf("vec%0d_irq", v), {31'h0, irq_v[0]}, {31'h0, vecs[v].exp_irq});
    end

    // irq follows EDGECAP by exactly one edge
    wr(2'd3, 32'hF);
    in_port = 4'h4;
    idle(LAT);
    chk("irq_lat_before", {31'h0, irq_v[0]}, 32'h0);
    step();
    chk("irq_lat_after", {31'h0, irq_v[0]}, 32'h1);

    // edge arriving in the same cycle as its clear wins
    wr(2'd3, 32'hF);
    in_port = 4'h0;
    idle(LAT + 2);
    wr(2'd3, 32'hF);
    in_port = 4'h2;
    idle(LAT - 1);
    wr(2'd3, 32'h2);
    rd(2'd3);
    chk("set_beats_clr_rise", rdata[0], 32'h2);
    chk("set_beats_clr_any", rdata[2], 32'h2);

    // falling edge on all bits
    in_port = 4'hF;
    idle(LAT + 2);
    wr(2'd3, 32'hF);
    in_port = 4'h0;
    idle(LAT + 2);
    rd(2'd3);
    chk("fall_all", rdata[1], 32'hF);
    chk("fall_rise_none", rdata[0], 32'h0);

    // any edge: 0->1 and 1->0 each set bit 0
    wr(2'd3, 32'hF);
    in_port = 4'h1;
    idle(LAT + 2);
    rd(2'd3);
    chk("any_up", rdata[2], 32'h1);
    wr(2'd3, 32'h1);
    rd(2'd3);
    chk("any_cleared", rdata[2], 32'h0);
    in_port = 4'h0;
    idle(LAT + 2);
    rd(2'd3);
    chk("any_down", rdata[2], 32'h1);

    // reset in the middle of operation
    wr(2'd2, 32'hF);
    wr(2'd3, 32'hF);
    in_port = 4'hF;
    idle(LAT + 2);
    chk("pre_reset_irq", {31'h0, irq_v[0]}, 32'h1);
    #2 reset_n = 1'b0;
    model_clear();
    #1;
    for (int t = 0; t < 3; t++) begin
      chk("async_reset_irq", {31'h0, irq_v[t]}, 32'h0);
      chk("async_reset_rd", rdata[t], 32'h0);
    end
    #2 reset_n = 1'b1;
    rd(2'd3);
    chk("post_reset_cap", rdata[0], 32'h0);
    chk("post_reset_cap_any", rdata[2], 32'h0);
    rd(2'd2);
    chk("post_reset_mask", rdata[0], 32'h0);

    // randomized traffic, every edge checked against the model
    for (int i = 0; i < 600; i++) begin
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) in_port = 4'($urandom_range(0, 15));
      step();
    end
    chipselect = 1'b0;
    write_n = 1'b1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soc_system_nios2arm_sel_in.md
SOC_SYSTEM_NIOS2ARM_SEL_IN -- requirements
Module: soc_system_nios2arm_sel_in

Interface
REQ-001 Parameter WIDTH, default 4: width of in_port and of the data, mask and capture registers.
REQ-002 Parameter EDGE_TYPE, default 0: 0 rising, 1 falling, 2 any edge.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 address  input  2  Avalon-MM word address.
REQ-006 chipselect  input  1  Avalon-MM slave select.
REQ-007 write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 writedata  input  32  Avalon-MM write data.
REQ-009 in_port  input  WIDTH  selector from the Nios side, asynchronous to clk.
REQ-010 readdata  output  32  Avalon-MM read data; bits above WIDTH read 0.
REQ-011 irq  output  1  level interrupt to the ARM side, active-high.

Function
REQ-012 Register map: address 0 is DATA (RO); 1 reserved; 2 is IRQMASK (RW); 3 is EDGECAP (R, write-1-to-clear).
REQ-013 in_port shall pass through the input stage (REQ-030/031) to give sample s; prev holds s from the previous cycle.
REQ-014 DATA shall read s.
REQ-015 Edge vector e[i] shall be s[i]&~prev[i] (EDGE_TYPE 0), ~s[i]&prev[i] (1), or s[i]^prev[i] (2).
REQ-016 EDGECAP[i] shall set on e[i]=1 and hold until cleared.
REQ-017 A write to address 3 shall clear each EDGECAP bit whose writedata bit is 1; other bits are unchanged.
REQ-018 If e[i]=1 in the same cycle as a clear of bit i, the set wins and EDGECAP[i] ends the cycle at 1.
REQ-019 A write to address 2 shall load IRQMASK with writedata[WIDTH-1:0].
REQ-020 A write to address 0 or 1 shall have no effect.
REQ-021 irq shall equal |(EDGECAP & IRQMASK), driven from registers with no combinational path from bus inputs.
REQ-022 readdata shall be registered: readdata is updated at the posedge on which chipselect=1 and write_n=1, giving a read latency of 1 cycle.
REQ-023 readdata shall return the register selected by the address of that cycle, zero-extended.
REQ-024 readdata shall hold its value while no read is in progress.
REQ-025 Reads shall have no side effects; EDGECAP is not cleared on read.
REQ-026 A pulse on in_port shorter than one clk period is not guaranteed to be captured.

Reset
REQ-027 While reset_n=0: IRQMASK, EDGECAP, prev, synchronizer flops and readdata shall be 0, and irq shall be 0.
REQ-028 Reset shall take effect asynchronously on the falling edge of reset_n, and release shall be synchronous to clk.
REQ-029 No edge shall be captured on the first cycle after release: prev loads s at that cycle and compares on the next.

Configuration
REQ-030 With macro NIOS2ARM_SEL_SYNC_EN defined, in_port shall pass through a 2-flop synchronizer per bit before s.
- Change on in_port is visible in DATA and EDGECAP 3 clk edges later; irq asserts on the 4th edge.
REQ-031 With NIOS2ARM_SEL_SYNC_EN undefined, s shall be a single register of in_port.
- Latency drops to 1 and 2 edges respectively; all other behaviour is identical.

Verification
REQ-032 Reset mid-operation: EDGECAP=4'hF, IRQMASK=4'hF, pulse reset_n low for 3 ns off-edge -> irq=0 immediately; read addr 3 gives 0 and read addr 2 gives 0.
REQ-033 Rising capture: EDGE_TYPE=0, IRQMASK=4'b0100, in_port 0->4'b0110 -> EDGECAP=4'b0110 and irq=1 at the latency in REQ-030/031; read addr 0 gives 32'h6.
REQ-034 Write-1-to-clear: EDGECAP=4'b0110, write 32'h4 to addr 3 -> EDGECAP=4'b0010 and irq=0 with IRQMASK=4'b0100.
REQ-035 Simultaneous set and clear: an edge on bit 1 in the cycle of a write of 32'h2 to addr 3 -> EDGECAP[1]=1.
REQ-036 Falling/any edge: EDGE_TYPE=1, in_port 4'hF->4'h0 -> EDGECAP=4'hF; EDGE_TYPE=2, in_port 0->1->0 -> bit 0 set after each edge.
REQ-037 Read latency and ignored writes: write 32'hFFFF_FFFF to addr 0, then read addr 0 -> readdata equals in_port zero-extended one cycle after the read, and no register changes.
